// File: rtl/fft_frame_source_if.sv
// Output stream of the frame source: one complex entry per beat with
// sop/eop framing and valid/ready flow control.
interface fft_frame_source_if #(
  parameter int DATA_WIDTH = 20
);
  logic                  source_valid;
  logic                  source_ready;
  logic                  source_sop;
  logic                  source_eop;
  logic [DATA_WIDTH-1:0] source_re;
  logic [DATA_WIDTH-1:0] source_im;

  modport master (
    output source_valid, source_sop, source_eop, source_re, source_im,
    input  source_ready
  );

  modport slave (
    input  source_valid, source_sop, source_eop, source_re, source_im,
    output source_ready
  );
endinterface

// File: rtl/fft_frame_source.sv
// Frame packetiser: collects complex samples into BATCH_SIZE-entry frames in a
// ping-pong buffer and sends each complete frame as one sop/eop packet.
// The sample front-end is never stalled; samples arriving while the target
// bank is still full are dropped and counted.
module fft_frame_source #(
  parameter int BATCH_SIZE = 1024,
  parameter int DATA_WIDTH = 20,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  fft_frame_source_if.master    src,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  localparam int PTR_W = $clog2(BATCH_SIZE);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BATCH_SIZE - 1);

  typedef enum logic {IDLE, STREAM} rd_state_t;

  // Both banks live in one array; the bank bit is the top address bit.
  logic [2*DATA_WIDTH-1:0] mem [2*BATCH_SIZE];
  logic [1:0]              full;

  logic                    wr_bank;
  logic [PTR_W-1:0]        wr_ptr;

  // rd_bank/rd_ptr address the RAM read being issued; tx_bank is the bank whose
  // entries are currently leaving through the output register.
  rd_state_t               state_q, state_d;
  logic                    rd_bank;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    tx_bank;

  // Stage 1: registered RAM read plus its framing tags.
  logic                    p1_valid, p1_sop, p1_eop;
  logic [2*DATA_WIDTH-1:0] p1_data;

  logic out_en, issue, wr_en, wr_drop, wr_last, tx_eop;

  // The whole read pipeline advances only when the output register may load.
  assign out_en  = !src.source_valid || src.source_ready;
  assign wr_en   = in_valid && !full[wr_bank];
  assign wr_drop = in_valid &&  full[wr_bank];
  assign wr_last = wr_en && (wr_ptr == LAST_PTR);
  assign tx_eop  = src.source_valid && src.source_ready && src.source_eop;

  // Sample storage write port.
  // NOTE: the buffer RAM has no reset; the full flags alone say which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_ptr}] <= {in_re, in_im};
  end

  // Write pointer, bank select and overrun accounting.
  // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank    <= 1'b0;
      wr_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow <= wr_drop;
      if (wr_drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == LAST_PTR) wr_bank <= ~wr_bank;
      end
    end
  end

  // Bank full flags and frame completion: filling one bank and freeing the
  // other in the same cycle both take effect (they are never the same bank).
  always_ff @(posedge clk) begin
    if (reset) begin
      full        <= '0;
      tx_bank     <= 1'b0;
      frame_count <= '0;
    end else begin
      if (wr_last) full[wr_bank] <= 1'b1;
      if (tx_eop) begin
        full[tx_bank] <= 1'b0;
        tx_bank       <= ~tx_bank;
        frame_count   <= frame_count + 1'b1;
      end
    end
  end

  // Read FSM next state: issue one RAM read per pipeline advance while a full
  // bank is available; chain straight into the other bank when it is ready.
  // NOTE: outputs of this block get defaults first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (out_en && full[rd_bank]) begin
          issue   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_en) begin
          issue = 1'b1;
          if ((rd_ptr == LAST_PTR) && !full[~rd_bank]) state_d = IDLE;
        end
      end
    endcase
  end

  // Read FSM state and read address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_bank <= 1'b0;
      rd_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (rd_ptr == LAST_PTR) rd_bank <= ~rd_bank;
      end
    end
  end

  // Synchronous RAM read port, enabled only when a read is issued.
  always_ff @(posedge clk) begin
    if (issue) p1_data <= mem[{rd_bank, rd_ptr}];
  end

  // Stage-1 tags travelling alongside the RAM read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_valid <= 1'b0;
      p1_sop   <= 1'b0;
      p1_eop   <= 1'b0;
    end else if (out_en) begin
      p1_valid <= issue;
      p1_sop   <= issue && (rd_ptr == '0);
      p1_eop   <= issue && (rd_ptr == LAST_PTR);
    end
  end

  // Output register: loads when empty or accepted, otherwise holds the beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      src.source_valid <= 1'b0;
      src.source_sop   <= 1'b0;
      src.source_eop   <= 1'b0;
      src.source_re    <= '0;
      src.source_im    <= '0;
    end else if (out_en) begin
      src.source_valid <= p1_valid;
      src.source_sop   <= p1_sop;
      src.source_eop   <= p1_eop;
      src.source_re    <= p1_valid ? p1_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
      src.source_im    <= p1_valid ? p1_data[DATA_WIDTH-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_fft_frame_source.sv
// Scoreboard bench for fft_frame_source with BATCH_SIZE=8. Stimulus pushes the
// expected beats of every frame it completes; a negedge monitor pops and
// compares each transferred beat and checks that stalled beats stay stable.
module tb_fft_frame_source;
  localparam int BATCH = 8;
  localparam int DW    = 20;
  localparam int CW    = 8;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_re, in_im;
  logic          overflow;
  logic [CW-1:0] drop_count, frame_count;

  fft_frame_source_if #(.DATA_WIDTH(DW)) src_if ();

  fft_frame_source #(.BATCH_SIZE(BATCH), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_re       (in_re),
    .in_im       (in_im),
    .src         (src_if),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    ovf_cnt = 0;
  bit    mon_en = 1'b0;
  bit    hold_pending = 1'b0;
  beat_t held, cur, exp_b;
  beat_t exp_q[$];
  int    sop_cycles[$];
  int    eop_cycles[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input int v, input int idx);
    beat_t b;
    b.sop = (idx == 0);
    b.eop = (idx == BATCH - 1);
    b.re  = DW'(v);
    b.im  = DW'(-v);
    exp_q.push_back(b);
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_re    = DW'(v);
    in_im    = DW'(-v);
    @(posedge clk); #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || src_if.source_valid) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, "_drain_in_time"}, (t < 300), 1);
    check({name, "_beats_left"}, exp_q.size(), 0);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: scoreboard pop on every transfer, stability check on every stall.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {src_if.source_sop, src_if.source_eop, src_if.source_re, src_if.source_im};
      if (overflow) ovf_cnt++;
      if (hold_pending) check("stalled_beat_stable", cur, held);
      if (src_if.source_valid && src_if.source_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL beat_unexpected: got 0x%0h, expected no beat (t=%0t)", cur, $time);
        end else begin
          exp_b = exp_q.pop_front();
          check("beat", cur, exp_b);
        end
        if (cur.sop) sop_cycles.push_back(cyc);
        if (cur.eop) eop_cycles.push_back(cyc);
      end
      hold_pending = src_if.source_valid && !src_if.source_ready;
      held = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int gap;
    reset = 1'b1;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    src_if.source_ready = 1'b1;
    tick(3);

    // Reset state
    check("rst_valid", src_if.source_valid, 0);
    check("rst_sop_eop", {src_if.source_sop, src_if.source_eop}, 0);
    check("rst_data", {src_if.source_re, src_if.source_im}, 0);
    check("rst_counters", {overflow, drop_count, frame_count}, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // 1: single frame re=k, im=-k; valid with sop two edges after the last write
    for (int k = 0; k < BATCH; k++) begin add(k, k); send(k); end
    in_valid = 1'b0;
    tick(1);
    check("lat_valid_early", src_if.source_valid, 0);
    tick(1);
    check("lat_valid_n2", {src_if.source_valid, src_if.source_sop}, 2'b11);
    drain("f1");
    check("f1_frame_count", frame_count, 1);

    // 2: sixteen consecutive samples, no bubble between eop and next sop
    sop_cycles.delete(); eop_cycles.delete();
    for (int k = 0; k < 2*BATCH; k++) begin add(32 + k, k % BATCH); send(32 + k); end
    in_valid = 1'b0;
    drain("f2");
    check("f2_sop_count", sop_cycles.size(), 2);
    check("f2_eop_count", eop_cycles.size(), 2);
    gap = (sop_cycles.size() == 2 && eop_cycles.size() >= 1) ? sop_cycles[1] - eop_cycles[0] : -1;
    check("f2_eop_to_sop_gap", gap, 1);
    check("f2_frame_count", frame_count, 3);

    // 3: ready low while 24 samples arrive; the last 8 are dropped
    ovf_cnt = 0;
    src_if.source_ready = 1'b0;
    for (int k = 0; k < 3*BATCH; k++) begin
      if (k < 2*BATCH) add(256 + k, k % BATCH);
      send(256 + k);
    end
    in_valid = 1'b0;
    tick(2);
    check("ovr_drop_count", drop_count, 8);
    check("ovr_overflow_pulses", ovf_cnt, 8);
    check("ovr_stalled_head", {src_if.source_valid, src_if.source_sop, src_if.source_re}, {2'b11, DW'(256)});
    src_if.source_ready = 1'b1;
    drain("f3");
    check("f3_frame_count", frame_count, 5);

    // 4: ready toggling every cycle during a packet
    sop_cycles.delete(); eop_cycles.delete();
    for (int k = 0; k < BATCH; k++) begin add(512 + k, k); send(512 + k); end
    in_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      src_if.source_ready = ~src_if.source_ready;
      tick(1);
    end
    src_if.source_ready = 1'b1;
    drain("f4");
    check("f4_sop_count", sop_cycles.size(), 1);
    check("f4_eop_count", eop_cycles.size(), 1);
    check("f4_frame_count", frame_count, 6);

    // 5: reset at beat 3 with the next frame half loaded
    sop_cycles.delete(); eop_cycles.delete();
    for (int k = 0; k < BATCH; k++) begin add(768 + k, k); send(768 + k); end
    for (int k = 0; k < BATCH/2; k++) send(1024 + k);
    in_valid = 1'b0;
    tick(1);
    check("rst5_at_beat3", {src_if.source_valid, src_if.source_re}, {1'b1, DW'(768 + 3)});
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_q.delete();
    check("rst5_valid", src_if.source_valid, 0);
    check("rst5_sop_eop", {src_if.source_sop, src_if.source_eop}, 0);
    check("rst5_data", {src_if.source_re, src_if.source_im}, 0);
    check("rst5_counters", {overflow, drop_count, frame_count}, 0);
    check("rst5_no_eop", eop_cycles.size(), 0);
    for (int k = 0; k < BATCH; k++) begin add(1280 + k, k); send(1280 + k); end
    in_valid = 1'b0;
    drain("f5");
    check("f5_frame_count", frame_count, 1);
    check("f5_eop_count", eop_cycles.size(), 1);

    // 6: sustained overrun saturates drop_count; overflow keeps pulsing
    ovf_cnt = 0;
    src_if.source_ready = 1'b0;
    for (int k = 0; k < 2*BATCH; k++) begin add(2048 + k, k % BATCH); send(2048 + k); end
    for (int k = 0; k < 300; k++) send(4096 + k);
    in_valid = 1'b0;
    check("sat_overflow_still_pulsing", overflow, 1);
    tick(1);
    check("sat_drop_count", drop_count, 255);
    check("sat_overflow_pulses", ovf_cnt, 300);
    src_if.source_ready = 1'b1;
    drain("f6");
    check("f6_frame_count", frame_count, 3);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
